// File: rtl/rf_read_port_arbiter.sv
// Round-robin arbiter for the single register-array read port, with a 2-deep in-order
// tagged response queue. Define RDARB_PERF_EN to add conflict/stall perf counters.
module rf_read_port_arbiter_lane #(
  parameter int ADDR_W  = 7,
  parameter int ENTRIES = 128
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              oor
);
  assign oor = (32'(addr) >= 32'(ENTRIES));
endmodule

module rf_read_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int REQ_IDW = 2,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 16,
  parameter int ENTRIES = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      arr_busy,
  output logic                      arr_rd_en,
  output logic [ADDR_W-1:0]         arr_rd_id,
  input  logic [DATA_W-1:0]         arr_rd_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [REQ_IDW-1:0]        rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err
`ifdef RDARB_PERF_EN
  ,
  output logic [15:0]               perf_conflict_cnt,
  output logic [15:0]               perf_stall_cnt
`endif
);
  typedef struct packed {
    logic [REQ_IDW-1:0] id;
    logic               err;
    logic [DATA_W-1:0]  data;
  } rsp_t;

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_REQ-1:0]             oor;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign addr_a[g] = req_addr[g*ADDR_W +: ADDR_W];
    rf_read_port_arbiter_lane #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES)) u_lane (
      .addr (addr_a[g]),
      .oor  (oor[g])
    );
  end

  logic [REQ_IDW-1:0] rr_ptr, gnt_idx, rr_nxt, cand;
  logic               gnt_found, occ_ok, issue, pop;
  logic [1:0]         cnt;
  logic               infl, infl_err;
  logic [REQ_IDW-1:0] infl_id;
  rsp_t               q [2];
  logic               wr_ptr, rd_ptr;
  rsp_t               head;
  int                 idx;

  assign pop = rsp_valid & rsp_ready;
  // Queue plus in-flight read may never exceed two outstanding responses.
  assign occ_ok = ({1'b0, cnt} + {2'b0, infl}) < (3'd2 + {2'b0, pop});

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = REQ_IDW'(idx);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign rr_nxt    = (gnt_idx == REQ_IDW'(NUM_REQ-1)) ? '0 : gnt_idx + REQ_IDW'(1);
  // rst_n gates issue so no grant or strobe escapes while held in reset.
  assign issue     = rst_n & ~arr_busy & gnt_found & occ_ok;
  assign req_ready = issue ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign arr_rd_en = issue & ~oor[gnt_idx];
  assign arr_rd_id = arr_rd_en ? addr_a[gnt_idx] : '0;

  assign head      = q[rd_ptr];
  assign rsp_valid = (cnt != 2'd0);
  assign rsp_id    = rsp_valid ? head.id   : '0;
  assign rsp_err   = rsp_valid ? head.err  : 1'b0;
  assign rsp_data  = rsp_valid ? head.data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      infl     <= 1'b0;
      infl_err <= 1'b0;
      infl_id  <= '0;
      cnt      <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      q[0]     <= '0;
      q[1]     <= '0;
    end else begin
      infl     <= issue;
      infl_err <= issue & oor[gnt_idx];
      infl_id  <= gnt_idx;
      if (issue) rr_ptr <= rr_nxt;
      // Array data lands the cycle after the strobe; capture it straight into the tail.
      if (infl) begin
        q[wr_ptr] <= '{id: infl_id, err: infl_err, data: (infl_err ? '0 : arr_rd_data)};
        wr_ptr    <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, infl} - {1'b0, pop};
    end
  end

`ifdef RDARB_PERF_EN
  logic conflict, stall;
  assign conflict = |(req_valid & (req_valid - NUM_REQ'(1)));
  assign stall    = (|req_valid) & ~issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conflict_cnt <= 16'h0;
      perf_stall_cnt    <= 16'h0;
    end else begin
      if (conflict && perf_conflict_cnt != 16'hFFFF) perf_conflict_cnt <= perf_conflict_cnt + 16'h1;
      if (stall && perf_stall_cnt != 16'hFFFF)       perf_stall_cnt    <= perf_stall_cnt + 16'h1;
    end
  end
`endif
endmodule

// File: tb/tb_rf_read_port_arbiter.sv
// Randomized scoreboard bench for rf_read_port_arbiter (ENTRIES=100 so error reads occur).
module tb_rf_read_port_arbiter;
  localparam int N = 4, IDW = 2, AW = 7, DW = 16, ENT = 100;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*AW-1:0]   req_addr;
  logic              arr_busy, arr_rd_en, rsp_valid, rsp_ready, rsp_err;
  logic [AW-1:0]     arr_rd_id;
  logic [DW-1:0]     arr_rd_data, rsp_data;
  logic [IDW-1:0]    rsp_id;

  rf_read_port_arbiter #(.NUM_REQ(N), .REQ_IDW(IDW), .ADDR_W(AW), .DATA_W(DW), .ENTRIES(ENT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .arr_busy(arr_busy), .arr_rd_en(arr_rd_en), .arr_rd_id(arr_rd_id), .arr_rd_data(arr_rd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-array model: data valid the cycle after the strobe, junk otherwise.
  logic [DW-1:0] mem [128];
  always @(posedge clk) arr_rd_data <= arr_rd_en ? mem[arr_rd_id] : DW'($urandom);

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
  endtask

  typedef struct {
    int            id;
    bit            err;
    logic [DW-1:0] data;
    int            t;
  } exp_t;

  exp_t sb[$];
  int   pend[$];
  int   rr = 0;
  bit   run_chk = 1'b0;

  // Reference model: outstanding responses counted as grants not yet consumed.
  always @(negedge clk) if (rst_n && run_chk) begin
    bit            epop, allow;
    int            win;
    logic [AW-1:0] a;
    exp_t          e;
    epop  = rsp_ready && pend.size() > 0 && pend[0] + 2 <= cyc;
    allow = !arr_busy && (pend.size() - int'(epop)) < 2;
    win   = -1;
    if (allow)
      for (int k = 0; k < N; k++)
        if (win < 0 && req_valid[(rr + k) % N]) win = (rr + k) % N;
    chk("req_ready", 32'(req_ready), (win < 0) ? 32'(0) : 32'(1 << win));
    if (win >= 0) begin
      a      = req_addr[win*AW +: AW];
      e.id   = win;
      e.err  = (int'(a) >= ENT);
      e.data = e.err ? '0 : mem[a];
      e.t    = cyc;
      chk("arr_rd_en", 32'(arr_rd_en), 32'(!e.err));
      chk("arr_rd_id", 32'(arr_rd_id), e.err ? 32'(0) : 32'(a));
      sb.push_back(e);
      pend.push_back(cyc);
      rr = (win + 1) % N;
    end else begin
      chk("arr_rd_en idle", 32'(arr_rd_en), 32'(0));
      chk("arr_rd_id idle", 32'(arr_rd_id), 32'(0));
    end
    if (epop) void'(pend.pop_front());
  end

  // Monitor: head response must appear exactly two cycles after its grant, in order.
  always @(negedge clk) if (rst_n && run_chk) begin
    bit ev;
    ev = sb.size() > 0 && sb[0].t + 2 <= cyc;
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev && rsp_valid) begin
      chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
      chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
      chk("rsp_data", 32'(rsp_data), 32'(sb[0].data));
      if (rsp_ready) void'(sb.pop_front());
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_addr(input int r, input logic [AW-1:0] a);
    req_addr[r*AW +: AW] = a;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'(0));
    chk({tag, " arr_rd_en"}, 32'(arr_rd_en), 32'(0));
    chk({tag, " arr_rd_id"}, 32'(arr_rd_id), 32'(0));
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(0));
    chk({tag, " rsp_id"}, 32'(rsp_id), 32'(0));
    chk({tag, " rsp_data"}, 32'(rsp_data), 32'(0));
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = DW'($urandom);
    mem[5]    = 16'hBEEF;
    req_valid = '1;
    req_addr  = '0;
    rsp_ready = 1'b0;
    arr_busy  = 1'b0;
    step(3);
    chk_outs_zero("reset");
    rst_n = 1'b1;
    run_chk = 1'b1;
    req_valid = '0;
    step(1);

    // Single request to entry 5.
    set_addr(0, 7'h05);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    step(1);
    req_valid = '0;
    step(3);

    // Fairness: all requesters continuously valid.
    for (int r = 0; r < N; r++) set_addr(r, AW'($urandom_range(0, ENT-1)));
    req_valid = '1;
    step(16);

    // Backpressure: two outstanding max, then a single pop frees one grant.
    rsp_ready = 1'b0;
    step(5);
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0;
    step(3);
    rsp_ready = 1'b1;
    req_valid = '0;
    step(4);

    // Out-of-range accesses, including both sides of the ENTRIES boundary.
    set_addr(2, 7'd120);
    req_valid = 4'b0100;
    step(1);
    set_addr(1, 7'd99);
    set_addr(3, 7'd100);
    req_valid = 4'b1010;
    step(2);
    req_valid = '0;
    step(3);

    // Array busy blocks issue; grants resume from the round-robin pointer.
    arr_busy  = 1'b1;
    req_valid = '1;
    step(4);
    arr_busy = 1'b0;
    step(4);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      for (int r = 0; r < N; r++) set_addr(r, AW'($urandom_range(0, 127)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      arr_busy  = ($urandom_range(0, 9) == 0);
      step(1);
    end

    // Reset with responses queued and a read in flight.
    arr_busy  = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '1;
    step(3);
    rst_n = 1'b0;
    run_chk = 1'b0;
    #1;
    chk_outs_zero("midreset");
    sb.delete();
    pend.delete();
    rr = 0;
    step(1);
    rst_n = 1'b1;
    run_chk = 1'b1;
    rsp_ready = 1'b1;
    step(8);

    // Drain everything that was granted.
    req_valid = '0;
    for (int c = 0; c < 20 && sb.size() > 0; c++) step(1);
    chk("drain empty", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
